// File: rtl/param_fifo.sv
// param_fifo: synchronous single-clock FIFO with first-word fall-through read
// and a valid/ready handshake on both sides.
//
// Parameters:
//   WIDTH    data width in bits (>= 1)
//   DEPTH    number of entries, power of two (>= 2)
//   AF_LEVEL almost_full threshold, 1..DEPTH (almost_full = count >= AF_LEVEL)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     write side (push = in_valid & in_ready)
//   out_valid/out_ready/out_data  read side  (pop  = out_valid & out_ready)
//   count                   stored entries, 0..DEPTH
//   almost_full             registered, count >= AF_LEVEL
//
// Optional feature: define PARAM_FIFO_BYPASS_EN to let a word offered to an
// empty FIFO appear on out_data in the same cycle; if it is taken in that
// cycle it is never stored.
module param_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             almost_full_q, almost_full_d;
    logic             in_ready_q, in_ready_d;
    logic             stored_valid_q, stored_valid_d;

    logic             push, pop, wr_en, rd_en, bypass_take;

    // Read side: head of storage, or (bypass build) the incoming word when empty.
`ifdef PARAM_FIFO_BYPASS_EN
    assign out_valid   = stored_valid_q | in_valid;
    assign out_data    = stored_valid_q ? mem_q[rd_ptr_q] : in_data;
    assign bypass_take = ~stored_valid_q & in_valid & out_ready;
`else
    assign out_valid   = stored_valid_q;
    assign out_data    = mem_q[rd_ptr_q];
    assign bypass_take = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;

    assign push  = in_valid & in_ready_q;
    assign pop   = out_valid & out_ready;
    // A bypassed word touches neither storage nor pointers.
    assign wr_en = push & ~bypass_take;
    assign rd_en = pop & ~bypass_take;

    // Next-state: pointers, occupancy and flags decoded from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d     = (count_d != CW'(DEPTH));
        stored_valid_d = (count_d != CW'(0));
        almost_full_d  = (count_d >= CW'(AF_LEVEL));
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            almost_full_q  <= 1'b0;
            in_ready_q     <= 1'b1;
            stored_valid_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            almost_full_q  <= almost_full_d;
            in_ready_q     <= in_ready_d;
            stored_valid_q <= stored_valid_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

endmodule
